// File: rtl/ysyx_25020047_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020047_mem_pkg
// Purpose  : Shared definitions for the LSU memory responder: response codes,
//            data/strobe widths, FSM state encoding and LFSR constants used by
//            the optional random-delay mode (YSYX_25020047_MEM_RAND_DELAY_EN).
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_25020047_mem_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_RESP = 3'd2,
    WR_WAIT = 3'd3,
    WR_RESP = 3'd4
  } mem_state_e;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_25020047_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020047_mem_array
// Purpose  : DEPTH x 32-bit word storage with one byte-enabled synchronous
//            write port and one combinational read port. Not reset.
// Ports    : clk      - clock
//            i_we     - write enable
//            i_widx   - write word index
//            i_wdata  - write data (lane-positioned)
//            i_wstrb  - byte enables, bit i -> i_wdata[8i+7:8i]
//            i_ridx   - read word index
//            o_rdata  - read data (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25020047_mem_array
  import ysyx_25020047_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule
`default_nettype wire

// File: rtl/ysyx_25020047_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020047_mem_resp
// Purpose  : AXI4-Lite-style memory responder for the core LSU. Serialises one
//            transaction at a time, round-robin arbitrates contested read /
//            write requests, waits LATENCY cycles, then responds. Writes are
//            committed to the array in the cycle bvalid rises.
// Config   : define YSYX_25020047_MEM_RAND_DELAY_EN to add a per-transaction
//            random extra wait of 0..3 cycles drawn from a 16-bit LFSR.
// Ports    : clk, rst (sync, active-high)
//            AR: araddr, arvalid, arready      R: rdata, rresp, rvalid, rready
//            AW: awaddr, awvalid, awready      W: wdata, wstrb, wvalid, wready
//            B : bresp, bvalid, bready
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25020047_mem_resp
  import ysyx_25020047_mem_pkg::*;
#(
  parameter int                 ADDR_W  = 32,
  parameter int                 DEPTH   = 1024,
  parameter logic [ADDR_W-1:0]  BASE    = ADDR_W'(32'h8000_0000),
  parameter int                 LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough for LATENCY plus the largest random extra wait (3)
  localparam int                CNT_W   = $clog2(LATENCY + 5);
  localparam logic [CNT_W-1:0]  c_lat   = CNT_W'(LATENCY);
  localparam logic [ADDR_W:0]   c_limit = {1'b0, BASE} + (ADDR_W+1)'(4 * DEPTH);

  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < c_limit);
  endfunction

  function automatic logic [IDX_W-1:0] f_index(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE) >> 2);
  endfunction

  mem_state_e          r_state;
  mem_state_e          w_state_nxt;
  logic                r_rr_last;     // 1: write won the last contested grant
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_in_range;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic [31:0]         r_rdata;
  logic [1:0]          r_rresp;
  logic [1:0]          r_bresp;
  logic                r_rvalid;
  logic                r_bvalid;

  logic                w_rd_elig;
  logic                w_wr_elig;
  logic                w_idle;
  logic                w_grant_rd;
  logic                w_grant_wr;
  logic [CNT_W-1:0]    w_wait;
  logic                w_load_rd;
  logic                w_commit;
  logic                w_from_idle;
  logic [IDX_W-1:0]    w_ridx;
  logic                w_r_in_range;
  logic [IDX_W-1:0]    w_widx;
  logic                w_w_in_range;
  logic [31:0]         w_cm_wdata;
  logic [3:0]          w_cm_wstrb;
  logic                w_we;
  logic [31:0]         w_mem_rdata;

  // ---------------------------------------------------------------------------
  // Arbitration: write needs both AW and W; a tie goes to the loser of the
  // previous tie. Nothing is granted while in reset or outside IDLE.
  // ---------------------------------------------------------------------------
  assign w_rd_elig  = arvalid;
  assign w_wr_elig  = awvalid && wvalid;
  assign w_idle     = (r_state == IDLE) && !rst;
  assign w_grant_rd = w_idle && w_rd_elig && (!w_wr_elig || r_rr_last);
  assign w_grant_wr = w_idle && w_wr_elig && (!w_rd_elig || !r_rr_last);

  assign arready = w_grant_rd;
  assign awready = w_grant_wr;
  assign wready  = w_grant_wr;

`ifdef YSYX_25020047_MEM_RAND_DELAY_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_wait = c_lat + CNT_W'(r_lfsr[1:0]);
`else
  assign w_wait = c_lat;
`endif

  // ---------------------------------------------------------------------------
  // With zero wait the response is produced straight from IDLE, so the array
  // ports take the live request fields there and the latched ones otherwise.
  // ---------------------------------------------------------------------------
  assign w_from_idle  = (r_state == IDLE);
  assign w_ridx       = w_from_idle ? f_index(araddr)    : r_idx;
  assign w_r_in_range = w_from_idle ? f_in_range(araddr) : r_in_range;
  assign w_widx       = w_from_idle ? f_index(awaddr)    : r_idx;
  assign w_w_in_range = w_from_idle ? f_in_range(awaddr) : r_in_range;
  assign w_cm_wdata   = w_from_idle ? wdata              : r_wdata;
  assign w_cm_wstrb   = w_from_idle ? wstrb              : r_wstrb;

  // Reset gates the commit so a pending write never reaches the array
  assign w_we = w_commit && w_w_in_range && !rst;

  ysyx_25020047_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_widx  (w_widx),
    .i_wdata (w_cm_wdata),
    .i_wstrb (w_cm_wstrb),
    .i_ridx  (w_ridx),
    .o_rdata (w_mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_load_rd   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_rd) begin
          w_load_rd   = (w_wait == '0);
          w_state_nxt = (w_wait == '0) ? RD_RESP : RD_WAIT;
        end else if (w_grant_wr) begin
          w_commit    = (w_wait == '0);
          w_state_nxt = (w_wait == '0) ? WR_RESP : WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (r_cnt == '0) begin
          w_load_rd   = 1'b1;
          w_state_nxt = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rready) begin
          w_state_nxt = IDLE;
        end
      end
      WR_WAIT: begin
        if (r_cnt == '0) begin
          w_commit    = 1'b1;
          w_state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_last <= 1'b1;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_bresp   <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_rd_elig && w_wr_elig && (w_grant_rd || w_grant_wr)) begin
        r_rr_last <= w_grant_wr;
      end

      if (w_grant_rd || w_grant_wr) begin
        // Wait state holds for w_wait cycles: load w_wait-1 and count to 0
        r_cnt <= (w_wait == '0) ? '0 : (w_wait - 1'b1);
      end else if (((r_state == RD_WAIT) || (r_state == WR_WAIT)) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_grant_rd) begin
        r_idx      <= f_index(araddr);
        r_in_range <= f_in_range(araddr);
      end else if (w_grant_wr) begin
        r_idx      <= f_index(awaddr);
        r_in_range <= f_in_range(awaddr);
        r_wdata    <= wdata;
        r_wstrb    <= wstrb;
      end

      if (w_load_rd) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_r_in_range ? w_mem_rdata : 32'h0;
        r_rresp  <= w_r_in_range ? RESP_OKAY : RESP_DECERR;
      end else if (r_rvalid && rready) begin
        r_rvalid <= 1'b0;
      end

      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_w_in_range ? RESP_OKAY : RESP_DECERR;
      end else if (r_bvalid && bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  assign rdata  = r_rdata;
  assign rresp  = r_rresp;
  assign rvalid = r_rvalid;
  assign bresp  = r_bresp;
  assign bvalid = r_bvalid;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25020047_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25020047_mem_resp
// Purpose  : Scoreboard bench for ysyx_25020047_mem_resp. Stimulus tasks push
//            expected responses computed from a word-array reference model;
//            a monitor compares them whenever a response is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25020047_mem_resp;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;

  ysyx_25020047_mem_resp #(
    .ADDR_W  (32),
    .DEPTH   (DEPTH),
    .BASE    (BASE),
    .LATENCY (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_wr;
    logic [31:0] data;
    logic [1:0]  resp;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [DEPTH];
  bit          tb_last_wr = 1'b1;   // side that won the last tie
  int          rdy_mode = 0;        // 0: always ready, 1: random, 2: stall
  int          last_hs = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Reference model: state changes in acceptance order, one at a time.
  task automatic model_read(input logic [31:0] a, input int acc);
    exp_t e;
    e.is_wr = 1'b0;
    e.data  = in_rng(a) ? model[widx(a)] : 32'h0;
    e.resp  = in_rng(a) ? 2'b00 : 2'b11;
    e.due   = acc + 1 + LAT;
    sbq.push_back(e);
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int acc);
    exp_t e;
    if (in_rng(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
      end
    end
    e.is_wr = 1'b1;
    e.data  = 32'h0;
    e.resp  = in_rng(a) ? 2'b00 : 2'b11;
    e.due   = acc + 1 + LAT;
    sbq.push_back(e);
  endtask

  // Response-side ready drivers
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: begin rready = 1'b1; bready = 1'b1; end
      1: begin rready = ($urandom_range(0, 2) != 0); bready = ($urandom_range(0, 2) != 0); end
      default: begin rready = 1'b0; bready = 1'b0; end
    endcase
  end

  // Monitor
  bit prev_rv = 1'b0;
  bit prev_bv = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_rv = 1'b0;
      prev_bv = 1'b0;
    end else begin
      if (rvalid || bvalid)
        check("no_grant_while_busy", 32'({arready, awready, wready}), 32'h0);
      if (rvalid && !prev_rv) begin
        if (sbq.size() == 0 || sbq[0].is_wr) begin
          checks++; errors++;
          $display("FAIL unexpected_rvalid: rvalid=1 at cycle %0d, expected no read pending", cyc);
        end else begin
          check("r_latency", 32'(cyc), 32'(sbq[0].due));
        end
      end
      if (bvalid && !prev_bv) begin
        if (sbq.size() == 0 || !sbq[0].is_wr) begin
          checks++; errors++;
          $display("FAIL unexpected_bvalid: bvalid=1 at cycle %0d, expected no write pending", cyc);
        end else begin
          check("b_latency", 32'(cyc), 32'(sbq[0].due));
        end
      end
      if (rvalid && sbq.size() > 0 && !sbq[0].is_wr) begin
        check("rdata", rdata, sbq[0].data);
        check("rresp", 32'(rresp), 32'(sbq[0].resp));
        if (rready) begin
          void'(sbq.pop_front());
          last_hs = cyc;
        end
      end
      if (bvalid && sbq.size() > 0 && sbq[0].is_wr) begin
        check("bresp", 32'(bresp), 32'(sbq[0].resp));
        if (bready) begin
          void'(sbq.pop_front());
          last_hs = cyc;
        end
      end
      prev_rv = rvalid;
      prev_bv = bvalid;
    end
  end

  // Waits for a grant; returns the cycle in which the handshake is visible.
  task automatic wait_grant(input bit want_wr, output int acc, output bit ok);
    ok  = 1'b0;
    acc = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (want_wr ? awready : arready) begin
        ok  = 1'b1;
        acc = cyc;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL grant_timeout: no %s grant within 400 cycles", want_wr ? "write" : "read");
    end
  endtask

  task automatic do_read(input logic [31:0] a, output int acc);
    bit ok;
    araddr  = a;
    arvalid = 1'b1;
    wait_grant(1'b0, acc, ok);
    if (ok) model_read(a, acc);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok;
    int acc;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    wait_grant(1'b1, acc, ok);
    if (ok) begin
      check("wready_with_awready", 32'(wready), 32'h1);
      model_write(a, d, s, acc);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  // Read and write presented together: the tie goes to the side that lost
  // the previous tie.
  task automatic do_pair(input logic [31:0] ra, input logic [31:0] wa,
                         input logic [31:0] d, input logic [3:0] s);
    bit exp_wr;
    bit got;
    int acc;
    exp_wr = !tb_last_wr;
    araddr = ra; arvalid = 1'b1;
    awaddr = wa; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (arready || awready) begin got = 1'b1; acc = cyc; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL pair_grant_timeout: no grant within 400 cycles");
      @(posedge clk); #1;
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    end else begin
      check("arb_grant", 32'({arready, awready}), exp_wr ? 32'h1 : 32'h2);
      tb_last_wr = exp_wr;
      if (exp_wr) begin
        model_write(wa, d, s, acc);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        do_read(ra, acc);
      end else begin
        model_read(ra, acc);
        @(posedge clk); #1;
        arvalid = 1'b0;
        do_write(wa, d, s);
      end
    end
  endtask

  task automatic wait_empty();
    for (int n = 0; n < 2000 && sbq.size() != 0; n++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sbq.size());
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0)      return BASE - 32'd4;
    else if (r == 1) return BASE + 32'(4 * DEPTH);
    else if (r == 2) return $urandom;
    else             return BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
  endfunction

  initial begin
    int acc, acc2;
    bit ok;

    // Reset: requests presented during reset must not be granted
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_readies", 32'({arready, awready, wready}), 32'h0);
    check("rst_valids", 32'({rvalid, bvalid}), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_resps", 32'({rresp, bresp}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;

    // Fill the whole array so every word has a known value
    for (int i = 0; i < DEPTH; i++)
      do_write(BASE + 32'(4 * i), (32'(i) * 32'h9E37_79B9) ^ 32'h1357_2468, 4'hF);

    // Write then read back
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    do_read(32'h8000_0010, acc);

    // Byte / half-word strobes
    do_write(32'h8000_0020, 32'h1122_3344, 4'hF);
    do_write(32'h8000_0020, 32'h0000_AA00, 4'h2);
    do_read(32'h8000_0020, acc);
    do_write(32'h8000_0020, 32'hBBCC_0000, 4'hC);
    do_read(32'h8000_0020, acc);
    do_write(32'h8000_0024, 32'hFFFF_FFFF, 4'h0);
    do_read(32'h8000_0026, acc);

    // Out of range
    do_read(32'h7FFF_FFFC, acc);
    do_write(32'h8000_1000, 32'hCAFE_F00D, 4'hF);
    do_read(32'h8000_1000, acc);

    // Arbitration: first tie goes to read, second tie to write
    do_pair(32'h8000_0030, 32'h8000_0030, 32'h0102_0304, 4'hF);
    do_pair(32'h8000_0034, 32'h8000_0034, 32'hA5A5_5A5A, 4'h9);
    do_pair(32'h8000_0038, 32'h8000_003C, 32'h7777_8888, 4'h6);

    // Backpressure: stall rready, keep a second read pending
    wait_empty();
    rdy_mode = 2;
    do_read(BASE + 32'h40, acc);
    fork
      begin
        int n;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
          check("bp_rvalid_held", 32'(rvalid), 32'h1);
          @(negedge clk);
        end
        rdy_mode = 0;
      end
      do_read(BASE + 32'h44, acc2);
    join
    check("b2b_accept_cycle", 32'(acc2), 32'(last_hs + 1));

    // Randomised traffic with random response backpressure
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int          op;
      logic [31:0] a;
      logic [31:0] a2;
      op = $urandom_range(0, 9);
      a  = rand_addr();
      a2 = rand_addr();
      if (op < 4)      do_read(a, acc);
      else if (op < 8) do_write(a, $urandom, 4'($urandom_range(0, 15)));
      else             do_pair(a, a2, $urandom, 4'($urandom_range(0, 15)));
    end
    rdy_mode = 0;
    wait_empty();

    // Reset in the middle of a write: it must never commit
    awaddr = BASE; wdata = 32'h5555_5555; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    wait_grant(1'b1, acc, ok);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tb_last_wr = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_bvalid_after_reset", 32'(bvalid), 32'h0);
    end
    @(posedge clk); #1;
    do_read(BASE, acc);
    do_pair(BASE + 32'h8, BASE + 32'h8, 32'h0BAD_F00D, 4'h3);

    // Whole-array readback against the model
    for (int i = 0; i < DEPTH; i++) do_read(BASE + 32'(4 * i), acc);
    wait_empty();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
